// File: rtl/fir_sym_pkg.sv
// Shared state type and width/scaling helpers for the folded
// symmetric FIR.
package fir_sym_pkg;

   typedef enum logic {
      IDLE,
      ACC
   } state_t;

   function automatic int nc_f(input int taps);
      return (taps + 1) / 2;
   endfunction

   function automatic int pw_f(input int iw, input int cw);
      return iw + 1 + cw;
   endfunction

   function automatic int acc_w_f(
      input int iw,
      input int cw,
      input int taps
   );
      return pw_f(iw, cw) + $clog2(nc_f(taps));
   endfunction

   // Keep the top ow bits of an acc_w-bit sum, or sign-extend it.
   function automatic logic signed [63:0] scale_f(
      input logic signed [63:0] s,
      input int acc_w,
      input int ow
   );
      if (ow <= acc_w) return s >>> (acc_w - ow);
      return s;
   endfunction

endpackage

// File: rtl/fir_sym_mac.sv
// Pre-adder, multiplier, accumulator and output scaler shared
// by all coefficient pairs.
module fir_sym_mac
   import fir_sym_pkg::*;
#(
   parameter int IW    = 16,
   parameter int CW    = 8,
   parameter int OW    = 26,
   parameter int PW    = 25,
   parameter int ACC_W = 30
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 first,
   input  logic                 last,
   input  logic                 mode,
   input  logic signed [IW-1:0] a,
   input  logic signed [IW-1:0] b,
   input  logic signed [CW-1:0] coef,
   output logic                 valid,
   output logic signed [OW-1:0] dout
);

   logic signed [IW:0]      p;
   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum;

   always_comb begin
      p = mode ? (IW+1)'(a) - (IW+1)'(b)
               : (IW+1)'(a) + (IW+1)'(b);
      prod = PW'(p) * PW'(coef);
      sum = (first ? '0 : acc) + ACC_W'(prod);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc   <= '0;
         valid <= 1'b0;
         dout  <= '0;
      end else begin
         valid <= en & last;
         if (en) acc <= sum;
         if (en && last)
            dout <= OW'(scale_f(64'(sum), ACC_W, OW));
      end
   end

endmodule

// File: rtl/fir_filter_sym_folded.sv
// Multi-channel folded symmetric/anti-symmetric FIR: one term
// per clock over the half coefficient bank.
module fir_filter_sym_folded
   import fir_sym_pkg::*;
#(
   parameter int INPUT_WIDTH  = 16,
   parameter int COEFF_WIDTH  = 8,
   parameter int OUTPUT_WIDTH = 26,
   parameter int NUM_TAPS     = 37,
   parameter int NUM_CHANNELS = 2,
   parameter int COEFFS [(NUM_TAPS+1)/2] = '{
      8, 6, 0, -7, -11, -8, 0, 10, 16, 12,
      0, -16, -26, -22, 0, 38, 80, 114, 127},
   localparam int NC   = nc_f(NUM_TAPS),
   localparam int CH_W = (NUM_CHANNELS > 1) ?
                         $clog2(NUM_CHANNELS) : 1,
   localparam int KW   = $clog2(NC)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           valid_in,
   output logic                           ready_in,
   input  logic signed [INPUT_WIDTH-1:0]  din,
   input  logic [CH_W-1:0]                ch_in,
   input  logic                           sym_mode,
   input  logic                           coef_we,
   input  logic [KW-1:0]                  coef_addr,
   input  logic signed [COEFF_WIDTH-1:0]  coef_data,
   output logic                           valid_out,
   output logic [CH_W-1:0]                ch_out,
   output logic signed [OUTPUT_WIDTH-1:0] dout
);

   localparam int PW    = pw_f(INPUT_WIDTH, COEFF_WIDTH);
   localparam int ACC_W = acc_w_f(INPUT_WIDTH, COEFF_WIDTH,
                                  NUM_TAPS);
   localparam int TW    = $clog2(NUM_TAPS);

   state_t                        state_q;
   state_t                        state_d;
   logic [KW-1:0]                 k_q;
   logic [KW-1:0]                 k_d;
   logic [CH_W-1:0]               ch_q;
   logic                          mode_q;
   logic                          ch_ok;
   logic                          accept;
   logic                          en;
   logic                          first;
   logic                          last;
   logic                          mid;
   logic [TW-1:0]                 ia;
   logic [TW-1:0]                 ib;
   logic signed [INPUT_WIDTH-1:0] tap_a;
   logic signed [INPUT_WIDTH-1:0] tap_b;
   logic signed [INPUT_WIDTH-1:0] x [NUM_CHANNELS][NUM_TAPS];
   logic signed [COEFF_WIDTH-1:0] c [NC];

   assign ready_in = (state_q == IDLE);
   assign ch_ok    = int'(ch_in) < NUM_CHANNELS;
   assign accept   = valid_in & ready_in & ch_ok;
   assign first    = (k_q == '0);
   assign last     = (k_q == KW'(NC - 1));
   // Odd tap count: the centre tap has no partner.
   assign mid      = (NUM_TAPS % 2 == 1) && last;
   assign ia       = TW'(k_q);
   assign ib       = TW'(NUM_TAPS - 1 - int'(k_q));
   assign tap_a    = x[ch_q][ia];
   assign tap_b    = mid ? '0 : x[ch_q][ib];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         ch_q    <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         if (accept) begin
            ch_q   <= ch_in;
            mode_q <= sym_mode;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      en      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ACC;
               k_d     = '0;
            end
         end
         ACC: begin
            en = 1'b1;
            if (last) state_d = IDLE;
            else k_d = k_q + KW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++)
            for (int t = 0; t < NUM_TAPS; t++)
               x[ch][t] <= '0;
      end else if (accept) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (CH_W'(ch) == ch_in) begin
               x[ch][0] <= din;
               for (int t = 1; t < NUM_TAPS; t++)
                  x[ch][t] <= x[ch][t-1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NC; i++)
            c[i] <= COEFF_WIDTH'(COEFFS[i]);
      end else if (coef_we && ready_in &&
                   int'(coef_addr) < NC) begin
         c[coef_addr] <= coef_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) ch_out <= '0;
      else if (en && last) ch_out <= ch_q;
   end

   fir_sym_mac #(
      .IW   (INPUT_WIDTH),
      .CW   (COEFF_WIDTH),
      .OW   (OUTPUT_WIDTH),
      .PW   (PW),
      .ACC_W(ACC_W)
   ) u_mac (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .first(first),
      .last (last),
      .mode (mode_q),
      .a    (tap_a),
      .b    (tap_b),
      .coef (c[k_q]),
      .valid(valid_out),
      .dout (dout)
   );

endmodule

// File: tb/tb_fir_filter_sym_folded.sv
// Bench for the folded symmetric FIR: vector table, directed
// handshake/coefficient/reset sequences and a convolution model.
module tb_fir_filter_sym_folded;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               valid_in = 1'b0;
   logic               ready_in;
   logic signed [15:0] din = '0;
   logic [1:0]         ch_in = '0;
   logic               sym_mode = 1'b0;
   logic               coef_we = 1'b0;
   logic [4:0]         coef_addr = '0;
   logic signed [7:0]  coef_data = '0;
   logic               valid_out;
   logic [1:0]         ch_out;
   logic signed [29:0] dout;

   fir_filter_sym_folded #(
      .OUTPUT_WIDTH(30),
      .NUM_CHANNELS(3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .valid_in (valid_in),
      .ready_in (ready_in),
      .din      (din),
      .ch_in    (ch_in),
      .sym_mode (sym_mode),
      .coef_we  (coef_we),
      .coef_addr(coef_addr),
      .coef_data(coef_data),
      .valid_out(valid_out),
      .ch_out   (ch_out),
      .dout     (dout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     ch;
      int     din;
      bit     mode;
      longint exp;
   } vec_t;

   int K [19] = '{8, 6, 0, -7, -11, -8, 0, 10, 16, 12,
                  0, -16, -26, -22, 0, 38, 80, 114, 127};
   int cm [19];
   int hist [3][37];
   int n_cmp = 0;
   int n_bad = 0;
   vec_t tv [74];

   // Reference: full 37-tap impulse response built from the half
   // bank, convolved with the channel history (newest first).
   function automatic void m_push(input int ch, input int d);
      for (int t = 36; t > 0; t--) hist[ch][t] = hist[ch][t-1];
      hist[ch][0] = d;
   endfunction

   function automatic longint m_out(input int ch, input bit mode);
      longint s = 0;
      longint h;
      int j;
      for (int t = 0; t < 37; t++) begin
         j = (t < 19) ? t : 36 - t;
         h = cm[j];
         if (mode && t > 18) h = -h;
         s += h * hist[ch][t];
      end
      return s;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 19; i++) cm[i] = K[i];
      for (int ch = 0; ch < 3; ch++)
         for (int t = 0; t < 37; t++) hist[ch][t] = 0;
   endfunction

   task automatic check(input string nm, input longint got,
                        input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", nm, got, exp);
      end
   endtask

   task automatic to_fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got timeout, required response", nm);
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      @(negedge clk);
      while (!ready_in && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready_in) to_fail(nm);
   endtask

   task automatic send(input int ch, input int d, input bit mode,
                       input bit we, input int wa, input int wd,
                       output longint y, output int cho,
                       output int lat, output int rlo,
                       output bit ok);
      wait_ready("send_ready");
      valid_in = 1'b1;
      ch_in = 2'(ch);
      din = 16'(d);
      sym_mode = mode;
      coef_we = we;
      coef_addr = 5'(wa);
      coef_data = 8'(wd);
      @(negedge clk);
      valid_in = 1'b0;
      coef_we = 1'b0;
      lat = 0;
      rlo = 0;
      ok = 1'b0;
      y = 0;
      cho = 0;
      while (!ok && lat < 40) begin
         if (valid_out) begin
            ok = 1'b1;
            y = longint'(dout);
            cho = int'(ch_out);
         end else begin
            if (!ready_in) rlo++;
            @(negedge clk);
            lat++;
         end
      end
      if (!ok) to_fail("valid_out");
   endtask

   task automatic run(input int ch, input int d, input bit mode,
                      input bit we, input int wa, input int wd,
                      input string nm, output longint y);
      longint e;
      int cho, lat, rlo;
      bit ok;
      if (we && wa < 19) cm[wa] = wd;
      m_push(ch, d);
      e = m_out(ch, mode);
      send(ch, d, mode, we, wa, wd, y, cho, lat, rlo, ok);
      if (ok) begin
         check(nm, y, e);
         check({nm, "_ch"}, cho, ch);
      end
   endtask

   task automatic wr(input int a, input int d);
      wait_ready("wr_ready");
      coef_we = 1'b1;
      coef_addr = 5'(a);
      coef_data = 8'(d);
      @(negedge clk);
      coef_we = 1'b0;
      if (a < 19) cm[a] = d;
   endtask

   task automatic drop(input int d);
      int nv = 0;
      int nb = 0;
      wait_ready("drop_ready");
      valid_in = 1'b1;
      ch_in = 2'd3;
      din = 16'(d);
      sym_mode = 1'b0;
      @(negedge clk);
      valid_in = 1'b0;
      for (int j = 0; j < 22; j++) begin
         if (valid_out) nv++;
         if (!ready_in) nb++;
         @(negedge clk);
      end
      check("drop_valid_cnt", nv, 0);
      check("drop_busy_cnt", nb, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1);
   end

   initial begin
      longint y, e;
      int cho, lat, rlo, n, nacc, nval, gaps, last_j, j, d;
      bit ok;

      m_reset();
      for (int i = 0; i < 37; i++) begin
         j = (i < 19) ? i : 36 - i;
         tv[i].ch = 0;
         tv[i].din = (i == 0) ? 1 : 0;
         tv[i].mode = 1'b0;
         tv[i].exp = longint'(K[j]);
         tv[37+i].ch = 0;
         tv[37+i].din = (i == 0) ? 1 : 0;
         tv[37+i].mode = 1'b1;
         tv[37+i].exp = (i > 18) ? -longint'(K[j])
                                 : longint'(K[j]);
      end

      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", ready_in, 1);
      check("rst_valid", valid_out, 0);
      check("rst_dout", dout, 0);
      check("rst_ch", ch_out, 0);
      rst = 1'b1;

      for (int i = 0; i < 74; i++) begin
         m_push(tv[i].ch, tv[i].din);
         send(tv[i].ch, tv[i].din, tv[i].mode, 1'b0, 0, 0,
              y, cho, lat, rlo, ok);
         if (ok) check($sformatf("tbl%0d", i), y, tv[i].exp);
         if (i == 0) begin
            check("latency", lat, 19);
            check("ready_low", rlo, 19);
         end
      end

      // valid_in held: one accept every 20 cycles
      @(negedge clk);
      valid_in = 1'b1;
      ch_in = 2'd0;
      din = '0;
      sym_mode = 1'b0;
      nacc = 0;
      nval = 0;
      gaps = 0;
      last_j = -1;
      for (int jj = 0; jj < 61; jj++) begin
         if (valid_out) nval++;
         if (ready_in) begin
            if (last_j >= 0 && jj - last_j != 20) gaps++;
            last_j = jj;
            nacc++;
            m_push(0, 0);
         end
         @(negedge clk);
      end
      valid_in = 1'b0;
      check("hold_accepts", nacc, 4);
      check("hold_gaps", gaps, 0);
      check("hold_valids", nval, 3);
      repeat (25) @(negedge clk);

      drop(1234);

      for (int i = 0; i < 37; i++) begin
         run(0, (i == 0) ? 1 : 0, 1'b0, 1'b0, 0, 0, "iso0", y);
         if (i == 36) check("iso_ch0_last", y, 8);
         run(1, 100, 1'b0, 1'b0, 0, 0, "iso1", y);
         if (i == 36) check("iso_ch1_last", y, 51500);
      end

      wr(18, 0);
      for (int i = 0; i < 37; i++) begin
         run(0, (i == 0) ? 1 : 0, 1'b0, 1'b0, 0, 0, "c18", y);
         if (i == 18) check("c18_zero", y, 0);
      end

      // write while busy must be ignored
      m_push(2, 5);
      e = m_out(2, 1'b0);
      wait_ready("busy_ready");
      valid_in = 1'b1;
      ch_in = 2'd2;
      din = 16'sd5;
      sym_mode = 1'b0;
      @(negedge clk);
      valid_in = 1'b0;
      coef_we = 1'b1;
      coef_addr = 5'd0;
      coef_data = 8'sd55;
      @(negedge clk);
      coef_we = 1'b0;
      n = 0;
      while (!valid_out && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (valid_out) check("busy_out", longint'(dout), e);
      else to_fail("busy_out");
      wr(19, 55);
      for (int i = 0; i < 19; i++)
         run(0, (i == 0) ? 1 : 0, 1'b0, 1'b0, 0, 0, "nowr", y);
      run(0, 300, 1'b0, 1'b1, 0, -5, "wr_accept", y);

      for (int i = 0; i < 19; i++) wr(i, -128);
      for (int i = 0; i < 37; i++) begin
         run(1, -32768, 1'b0, 1'b0, 0, 0, "max", y);
         if (i == 36) check("max_last", y, 155189248);
      end

      for (int i = 0; i < 19; i++)
         wr(i, int'($urandom_range(0, 255)) - 128);
      wr(int'($urandom_range(19, 31)), 99);
      for (int i = 0; i < 45; i++) begin
         j = int'($urandom_range(0, 3));
         d = int'($urandom_range(0, 65535)) - 32768;
         if (j == 3) drop(d);
         else run(j, d, 1'($urandom_range(0, 1)), 1'b0, 0, 0,
                  "rnd", y);
      end

      // reset on the fifth ACC cycle aborts the sample
      wait_ready("rmid_ready");
      valid_in = 1'b1;
      ch_in = 2'd0;
      din = 16'sd777;
      sym_mode = 1'b0;
      @(negedge clk);
      valid_in = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("rmid_ready", ready_in, 1);
      check("rmid_valid", valid_out, 0);
      nval = 0;
      for (int jj = 0; jj < 25; jj++) begin
         if (valid_out) nval++;
         @(negedge clk);
      end
      check("rmid_no_out", nval, 0);
      m_reset();
      for (int i = 0; i < 37; i++) begin
         run(0, tv[i].din, 1'b0, 1'b0, 0, 0, "rimp", y);
         check($sformatf("rimp_tbl%0d", i), y, tv[i].exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
